mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage placed between execute and writeback. Accepts one instruction at a time from execute. Issues at most one aligned data-memory request per load/store, holds the instruction's writeback context until the access completes, and presents it to writeback with a one-cycle valid strobe. Assigns the retirement order number.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  stage accepts this cycle; accept = in_valid && in_ready
- in_op  in  4  memory op: 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6 sb, 7 sh, 8 sw; 9–15 treated as none
- in_addr  in  32  effective byte address; for loads/stores only
- in_wdata  in  32  store data, unshifted
- in_rd  in  5  destination register
- in_regf_we  in  1  instruction writes rd
- in_result  in  32  non-load writeback value
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_rmask  out  4  read byte mask; nonzero = read request
- dmem_wmask  out  4  write byte mask; nonzero = write request
- dmem_wdata  out  32  lane-shifted store data
- dmem_resp  in  1  access complete; earliest one cycle after request
- out_valid  out  1  writeback may consume out_* this cycle
- out_op, out_addr_lo[1:0], out_rd, out_regf_we, out_result, out_misaligned, out_order[63:0]  out  —  registered context captured at accept

## Operation
- States: IDLE, PASS, REQ, WAIT.
- On accept, from any state, capture all out_* fields:
  - out_addr_lo = in_addr[1:0].
  - out_order = order counter; the counter then increments by 1.
- Misalignment:
  - lh/lhu/sh are misaligned when addr[0]=1.
  - lw/sw are misaligned when addr[1:0]≠0.
  - A misaligned access sets out_misaligned=1 and forces out_regf_we=0. It issues no request and goes to PASS.
- Next state after accept:
  - Non-memory or misaligned op → PASS.
  - Aligned load/store → REQ.
- REQ drives the masks from the captured op and offset a:
  - lb/lbu/sb: 4'b0001<<a
  - lh/lhu/sh: 4'b0011<<a
  - lw/sw: 4'b1111
  - Loads drive rmask only; stores drive wmask only.
  - dmem_wdata = wdata<<(8*a), held from a register.
  - REQ → WAIT unconditionally.
- WAIT: masks are 0. dmem_addr and dmem_wdata hold. Stay until dmem_resp=1.
- out_valid:
  - 1 in PASS.
  - 1 in WAIT when dmem_resp=1.
  - 0 otherwise.
- in_ready = IDLE || PASS || (WAIT && dmem_resp).
- State leaving PASS or a completing WAIT:
  - Goes to the accepted instruction's next state if one is accepted that cycle.
  - Otherwise goes to IDLE.
- dmem_resp outside WAIT is ignored.
- Order counter: 64-bit, wraps 2^64−1 → 0.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - State IDLE, order counter 0.
  - All out_* 0, out_valid 0.
  - dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata all 0.
  - in_ready is 1 after reset.
- Reset asserted in REQ/WAIT abandons the access: masks drop to 0 immediately. A later dmem_resp arriving in IDLE is ignored.
- Non-memory latency: accept at edge N → out_valid in cycle N+1. Sustained throughput is 1/cycle.
- Memory latency: accept edge N → REQ in cycle N+1 → WAIT from N+2. out_valid coincides with dmem_resp. Minimum out_valid is in cycle N+2.
- The masks are nonzero for exactly one cycle per access.
- out_* change only at accept edges, so they are stable throughout WAIT and during the out_valid cycle.
- A simultaneous dmem_resp and in_valid in WAIT completes the current access and accepts the new instruction at the same edge.

## Test plan
- Reset release, then in_op=0, in_result=0x1234, in_rd=5 accepted:
  - Next cycle: out_valid=1, out_result=0x1234, out_order=0.
  - Four back-to-back ALU ops give orders 0,1,2,3 on consecutive cycles.
- sb at addr 0x1003, wdata 0xAB:
  - One cycle later: dmem_addr=0x1000, wmask=4'b1000, wdata=0xAB000000 for one cycle.
  - dmem_resp after 3 cycles of WAIT → out_valid pulses that cycle.
  - in_ready stays 0 until then.
- lh at 0x2002:
  - rmask=4'b1100, out_addr_lo=2.
  - A new ALU op held valid during WAIT is accepted in the dmem_resp cycle.
  - It shows out_valid the cycle after.
- lw at 0x3001:
  - No request; masks stay 0.
  - Next cycle: out_valid=1, out_misaligned=1, out_regf_we=0.
- rst_n pulsed low during WAIT of a load:
  - Masks and outputs are 0 immediately.
  - A dmem_resp one cycle after release produces no out_valid.
  - The order counter restarts at 0.
- in_op=12 with in_addr=0x5: treated as non-memory, no request, out_misaligned=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between execute and writeback.
// Holds one instruction's writeback context, issues at most one aligned
// data-memory access per load/store and assigns the retirement order number.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic        in_regf_we,
  input  logic [31:0] in_result,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp,
  output logic        out_valid,
  output logic [3:0]  out_op,
  output logic [1:0]  out_addr_lo,
  output logic [4:0]  out_rd,
  output logic        out_regf_we,
  output logic [31:0] out_result,
  output logic        out_misaligned,
  output logic [63:0] out_order
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPass = 2'd1;
  localparam logic [1:0] StReq  = 2'd2;
  localparam logic [1:0] StWait = 2'd3;

  // Access size: 0 none, 1 byte, 2 half, 3 word. Ops 9-15 decode as none.
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: op_size = 2'd1;
      4'd2, 4'd5, 4'd7: op_size = 2'd2;
      4'd3, 4'd8:       op_size = 2'd3;
      default:          op_size = 2'd0;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    op_is_load = (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    op_is_store = (op >= 4'd6) && (op <= 4'd8);
  endfunction

  logic [1:0]  state_q, state_d;
  logic [63:0] order_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [4:0]  rd_q;
  logic        regf_we_q;
  logic [31:0] result_q;
  logic        misaligned_q;
  logic [63:0] out_order_q;

  logic       accept;
  logic [1:0] in_size;
  logic       in_mem;
  logic       in_misaligned;
  logic [1:0] accept_state;
  logic [3:0] base_mask;
  logic [3:0] req_mask;

  // Decode the incoming instruction and pick the state it will start in.
  always_comb begin
    in_size       = op_size(in_op);
    in_mem        = (in_size != 2'd0);
    in_misaligned = ((in_size == 2'd2) && in_addr[0]) ||
                    ((in_size == 2'd3) && (in_addr[1:0] != 2'b00));
    accept_state  = (in_mem && !in_misaligned) ? StReq : StPass;
  end

  // Handshake and writeback strobe.
  always_comb begin
    in_ready  = (state_q == StIdle) || (state_q == StPass) ||
                ((state_q == StWait) && dmem_resp);
    accept    = in_valid && in_ready;
    out_valid = (state_q == StPass) || ((state_q == StWait) && dmem_resp);
  end

  // Next state: a new accept always wins; REQ lasts one cycle; WAIT holds until resp.
  always_comb begin
    state_d = StIdle;
    if (accept) begin
      state_d = accept_state;
    end else if (state_q == StReq) begin
      state_d = StWait;
    end else if ((state_q == StWait) && !dmem_resp) begin
      state_d = StWait;
    end
  end

  // Byte-lane masks are driven only during the single REQ cycle.
  always_comb begin
    case (op_size(op_q))
      2'd1:    base_mask = 4'b0001;
      2'd2:    base_mask = 4'b0011;
      2'd3:    base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
    req_mask   = (state_q == StReq) ? (base_mask << addr_lo_q) : 4'b0000;
    dmem_rmask = op_is_load(op_q)  ? req_mask : 4'b0000;
    dmem_wmask = op_is_store(op_q) ? req_mask : 4'b0000;
  end

  // FSM state and retirement order counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      order_q <= 64'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        order_q <= order_q + 64'd1;
      end
    end
  end

  // Capture the writeback context and, for aligned accesses, the request data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= 4'd0;
      addr_lo_q    <= 2'd0;
      rd_q         <= 5'd0;
      regf_we_q    <= 1'b0;
      result_q     <= 32'd0;
      misaligned_q <= 1'b0;
      out_order_q  <= 64'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
    end else if (accept) begin
      op_q         <= in_op;
      addr_lo_q    <= in_addr[1:0];
      rd_q         <= in_rd;
      regf_we_q    <= in_regf_we && !in_misaligned;
      result_q     <= in_result;
      misaligned_q <= in_misaligned;
      out_order_q  <= order_q;
      // Address and store data only move for a real request, so they hold in WAIT.
      if (in_mem && !in_misaligned) begin
        addr_q  <= {in_addr[31:2], 2'b00};
        wdata_q <= in_wdata << {in_addr[1:0], 3'b000};
      end
    end
  end

  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign out_op         = op_q;
  assign out_addr_lo    = addr_lo_q;
  assign out_rd         = rd_q;
  assign out_regf_we    = regf_we_q;
  assign out_result     = result_q;
  assign out_misaligned = misaligned_q;
  assign out_order      = out_order_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected writeback records.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        in_regf_we;
  logic [31:0] in_result;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic        out_valid;
  logic [3:0]  out_op;
  logic [1:0]  out_addr_lo;
  logic [4:0]  out_rd;
  logic        out_regf_we;
  logic [31:0] out_result;
  logic        out_misaligned;
  logic [63:0] out_order;

  mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_rd          (in_rd),
    .in_regf_we     (in_regf_we),
    .in_result      (in_result),
    .dmem_addr      (dmem_addr),
    .dmem_rmask     (dmem_rmask),
    .dmem_wmask     (dmem_wmask),
    .dmem_wdata     (dmem_wdata),
    .dmem_resp      (dmem_resp),
    .out_valid      (out_valid),
    .out_op         (out_op),
    .out_addr_lo    (out_addr_lo),
    .out_rd         (out_rd),
    .out_regf_we    (out_regf_we),
    .out_result     (out_result),
    .out_misaligned (out_misaligned),
    .out_order      (out_order)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] res;
    logic        mis;
    logic [63:0] ord;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_order = 64'd0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_mis(input logic [3:0] op, input logic [31:0] addr);
    case (op)
      4'd2, 4'd5, 4'd7: model_mis = addr[0];
      4'd3, 4'd8:       model_mis = (addr[1:0] != 2'b00);
      default:          model_mis = 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction, wait (bounded) for acceptance, record the expected result.
  task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] rd, input logic we, input logic [31:0] res);
    exp_t e;
    bit   ok = 1'b0;
    in_valid   = 1'b1;
    in_op      = op;
    in_addr    = addr;
    in_wdata   = wdata;
    in_rd      = rd;
    in_regf_we = we;
    in_result  = res;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_val("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    e.op  = op;
    e.lo  = addr[1:0];
    e.rd  = rd;
    e.mis = model_mis(op, addr);
    e.we  = we && !e.mis;
    e.res = res;
    e.ord = exp_order;
    exp_order = exp_order + 64'd1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // One aligned access: check the REQ cycle, hold WAIT for `waits` cycles, then respond.
  task automatic mem_access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_addr,
                            input logic [3:0] exp_r, input logic [3:0] exp_w,
                            input logic [31:0] exp_wd, input int waits);
    send(op, addr, wdata, 5'd1, 1'b1, 32'hC0DE);
    check_val({tag, "_req_addr"}, dmem_addr, exp_addr);
    check_val({tag, "_req_rmask"}, dmem_rmask, exp_r);
    check_val({tag, "_req_wmask"}, dmem_wmask, exp_w);
    if (exp_w != 4'd0) check_val({tag, "_req_wdata"}, dmem_wdata, exp_wd);
    check_val({tag, "_req_ready"}, in_ready, 0);
    tick();
    for (int i = 0; i < waits; i++) begin
      check_val({tag, "_wait_masks"}, {dmem_rmask, dmem_wmask}, 0);
      check_val({tag, "_wait_addr"}, dmem_addr, exp_addr);
      if (exp_w != 4'd0) check_val({tag, "_wait_wdata"}, dmem_wdata, exp_wd);
      check_val({tag, "_wait_ready"}, in_ready, 0);
      check_val({tag, "_wait_valid"}, out_valid, 0);
      tick();
    end
    dmem_resp = 1'b1;
    @(negedge clk);
    check_val({tag, "_resp_valid"}, out_valid, 1);
    check_val({tag, "_resp_ready"}, in_ready, 1);
    tick();
    dmem_resp = 1'b0;
    check_val({tag, "_after_valid"}, out_valid, 0);
  endtask

  // Scoreboard: every writeback strobe must match the oldest outstanding record.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        check_val("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("wb_op", out_op, e.op);
        check_val("wb_addr_lo", out_addr_lo, e.lo);
        check_val("wb_rd", out_rd, e.rd);
        check_val("wb_regf_we", out_regf_we, e.we);
        check_val("wb_result", out_result, e.res);
        check_val("wb_misaligned", out_misaligned, e.mis);
        check_val("wb_order", out_order, e.ord);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_op      = 4'd0;
    in_addr    = 32'd0;
    in_wdata   = 32'd0;
    in_rd      = 5'd0;
    in_regf_we = 1'b0;
    in_result  = 32'd0;
    dmem_resp  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_order", out_order, 0);
    check_val("rst_out_result", out_result, 0);
    check_val("rst_masks", {dmem_rmask, dmem_wmask}, 0);
    check_val("rst_dmem_addr", dmem_addr, 0);
    check_val("rst_dmem_wdata", dmem_wdata, 0);
    check_val("rst_in_ready", in_ready, 1);

    // Back-to-back ALU ops: one result per cycle, consecutive order numbers.
    for (int i = 0; i < 4; i++) begin
      send(4'd0, 32'd0, 32'd0, 5'd5, 1'b1, 32'h1234 + i);
      check_val("alu_valid", out_valid, 1);
      check_val("alu_result", out_result, 32'h1234 + i);
      check_val("alu_order", out_order, i);
    end
    tick();

    // sb to the top byte lane with a three-cycle WAIT.
    mem_access("sb", 4'd6, 32'h1003, 32'hAB, 32'h1000, 4'b0000, 4'b1000, 32'hAB00_0000, 3);
    mem_access("sw", 4'd8, 32'h10, 32'hDEAD_BEEF, 32'h10, 4'b0000, 4'b1111, 32'hDEAD_BEEF, 0);
    mem_access("sh", 4'd7, 32'h22, 32'h5A5A, 32'h20, 4'b0000, 4'b1100, 32'h5A5A_0000, 1);
    mem_access("lbu", 4'd4, 32'h1001, 32'd0, 32'h1000, 4'b0010, 4'b0000, 32'd0, 0);
    mem_access("lhu", 4'd5, 32'h1000, 32'd0, 32'h1000, 4'b0011, 4'b0000, 32'd0, 2);

    // lh with an ALU op waiting behind it; both complete at the resp edge.
    send(4'd2, 32'h2002, 32'd0, 5'd7, 1'b1, 32'd0);
    check_val("lh_rmask", dmem_rmask, 4'b1100);
    check_val("lh_wmask", dmem_wmask, 4'b0000);
    check_val("lh_addr_lo", out_addr_lo, 2);
    check_val("lh_addr", dmem_addr, 32'h2000);
    tick();
    fork
      send(4'd0, 32'd0, 32'd0, 5'd8, 1'b1, 32'h5555);
      begin
        tick();
        tick();
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
      end
    join
    check_val("lh_next_valid", out_valid, 1);
    check_val("lh_next_result", out_result, 32'h5555);
    tick();

    // Misaligned lw: no request, immediate writeback with regf_we suppressed.
    send(4'd3, 32'h3001, 32'd0, 5'd9, 1'b1, 32'h99);
    check_val("mis_masks", {dmem_rmask, dmem_wmask}, 0);
    check_val("mis_valid", out_valid, 1);
    check_val("mis_flag", out_misaligned, 1);
    check_val("mis_regf_we", out_regf_we, 0);
    tick();

    // Reset during the WAIT of a load abandons it; the late resp is ignored.
    send(4'd3, 32'h4000, 32'd0, 5'd10, 1'b1, 32'd0);
    check_val("rw_req_rmask", dmem_rmask, 4'b1111);
    tick();
    rst_n = 1'b0;
    sb_q.delete();
    exp_order = 64'd0;
    #1;
    check_val("rw_masks", {dmem_rmask, dmem_wmask}, 0);
    check_val("rw_out_valid", out_valid, 0);
    check_val("rw_out_order", out_order, 0);
    check_val("rw_out_rd", out_rd, 0);
    check_val("rw_dmem_addr", dmem_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    dmem_resp = 1'b1;
    @(negedge clk);
    check_val("rw_late_resp_valid", out_valid, 0);
    check_val("rw_late_resp_ready", in_ready, 1);
    tick();
    dmem_resp = 1'b0;
    send(4'd0, 32'd0, 32'd0, 5'd3, 1'b1, 32'h77);
    check_val("rw_order_restart", out_order, 0);
    tick();

    // Reserved op code behaves as non-memory even with an odd address.
    send(4'd12, 32'h5, 32'd0, 5'd4, 1'b1, 32'h42);
    check_val("op12_masks", {dmem_rmask, dmem_wmask}, 0);
    check_val("op12_valid", out_valid, 1);
    check_val("op12_mis", out_misaligned, 0);
    check_val("op12_op", out_op, 12);
    tick();
    tick();

    check_val("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
